// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// mem_access_unit: MEM pipeline stage. It turns EX/MEM load/store requests
// into request/grant/response transactions on one data-memory port. While an
// access is outstanding it holds the pipeline with stall_req_o, then writes
// back the aligned and extended load data, or the pass-through ALU result.
//
// Optional build macro: MEM_MISALIGN_SPLIT_EN
//   defined   -> an access that crosses a beat boundary is split into two beats
//   undefined -> every misaligned access faults; single-beat datapath only
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   in_valid_i, mem_op_i      EX/MEM slot valid / instruction accesses memory
//   mem_store_i, mem_size_i,  store flag, size (B/H/W/D), zero-extend load
//   mem_unsigned_i
//   ram_addr_i                effective byte address
//   w_enable_i/w_addr_i/      write-back controls from EX; w_data_i also
//   w_data_i                  carries the store data
//   w_enable_o/w_addr_o/      write-back to MEM/WB
//   w_data_o
//   stall_req_o, fault_o      pipeline hold, one-cycle access fault
//   mem_req_o ... mem_wdata_o memory request channel
//   mem_gnt_i, mem_rvalid_i,  grant and read response
//   mem_rdata_i
module mem_access_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    input  logic                  mem_op_i,
    input  logic                  mem_store_i,
    input  logic [1:0]            mem_size_i,
    input  logic                  mem_unsigned_i,
    input  logic [ADDR_W-1:0]     ram_addr_i,
    input  logic                  w_enable_i,
    input  logic [REG_ADDR_W-1:0] w_addr_i,
    input  logic [XLEN-1:0]       w_data_i,
    output logic                  w_enable_o,
    output logic [REG_ADDR_W-1:0] w_addr_o,
    output logic [XLEN-1:0]       w_data_o,
    output logic                  stall_req_o,
    output logic                  fault_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [XLEN/8-1:0]     mem_wmask_o,
    output logic [XLEN-1:0]       mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [XLEN-1:0]       mem_rdata_i
);
    localparam int unsigned BYTES = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned MW    = 2 * BYTES;
    localparam int unsigned DW    = 2 * XLEN;
`ifdef MEM_MISALIGN_SPLIT_EN
    localparam int unsigned BUF_W = DW;
`else
    localparam int unsigned BUF_W = XLEN;
`endif
    localparam bit D_LEGAL = (XLEN == 64);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e           state_q, state_d;
    logic             beat_q, beat_d;
    logic [BUF_W-1:0] rbuf_q, rbuf_d;

    logic [OFF_W-1:0]  off;
    logic [3:0]        nbytes;
    logic              is_mem;
    logic              size_bad;
    logic              reject;
    logic              more_beats;
    logic [ADDR_W-1:0] beat0_addr;
    logic [ADDR_W-1:0] beat_addr;
    logic [MW-1:0]     mask2;
    logic [DW-1:0]     wdata2;
    logic [XLEN-1:0]   rshift;
    logic [XLEN-1:0]   ld_data;

    // Access decode: lane offset, size, legality.
    assign off      = ram_addr_i[OFF_W-1:0];
    assign nbytes   = 4'd1 << mem_size_i;
    assign is_mem   = in_valid_i & mem_op_i;
    assign size_bad = (mem_size_i == 2'd3) && !D_LEGAL;

`ifdef MEM_MISALIGN_SPLIT_EN
    logic span2;
    // Access crosses into the next beat: needs a second request.
    assign span2      = (5'(off) + 5'(nbytes)) > 5'(BYTES);
    assign reject     = size_bad;
    assign more_beats = span2 & ~beat_q;
`else
    logic misaligned;
    assign misaligned = (ram_addr_i[2:0] & 3'(nbytes - 4'd1)) != 3'd0;
    assign reject     = size_bad | misaligned;
    assign more_beats = 1'b0;
`endif

    // Beat address, double-width store lanes, and load alignment.
    assign beat0_addr = {ram_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign beat_addr  = beat_q ? beat0_addr + ADDR_W'(BYTES) : beat0_addr;
    assign mask2      = ((MW'(1) << nbytes) - MW'(1)) << off;
    assign wdata2     = DW'(w_data_i) << {off, 3'b000};
    assign rshift     = XLEN'(rbuf_q >> {off, 3'b000});

    // Truncate to the access size, then sign- or zero-extend.
    always_comb begin
        case (mem_size_i)
            2'd0:    ld_data = XLEN'({{56{rshift[7]  & ~mem_unsigned_i}}, rshift[7:0]});
            2'd1:    ld_data = XLEN'({{48{rshift[15] & ~mem_unsigned_i}}, rshift[15:0]});
            2'd2:    ld_data = XLEN'({{32{rshift[31] & ~mem_unsigned_i}}, rshift[31:0]});
            default: ld_data = rshift;
        endcase
    end

    // Next state, beat counter and read buffer.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        rbuf_d  = rbuf_q;
        case (state_q)
            IDLE: begin
                if (is_mem && !reject) begin
                    state_d = REQ;
                    beat_d  = 1'b0;
                end
            end
            REQ: begin
                // A response never precedes its grant, so rvalid is ignored here.
                if (mem_gnt_i) begin
                    if (!mem_store_i) begin
                        state_d = WAIT;
                    end else if (more_beats) begin
                        beat_d = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
`ifdef MEM_MISALIGN_SPLIT_EN
                    if (beat_q) rbuf_d[DW-1:XLEN]   = mem_rdata_i;
                    else        rbuf_d[XLEN-1:0]    = mem_rdata_i;
`else
                    rbuf_d = mem_rdata_i;
`endif
                    if (more_beats) begin
                        state_d = REQ;
                        beat_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            beat_q  <= 1'b0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            rbuf_q  <= rbuf_d;
        end
    end

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        w_enable_o  = 1'b0;
        w_addr_o    = '0;
        w_data_o    = '0;
        stall_req_o = 1'b0;
        fault_o     = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wmask_o = '0;
        mem_wdata_o = '0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    w_addr_o = w_addr_i;
                    w_data_o = w_data_i;
                    if (!is_mem)     w_enable_o  = w_enable_i;
                    else if (reject) fault_o     = 1'b1;
                    else             stall_req_o = 1'b1;
                end
                REQ: begin
                    stall_req_o = 1'b1;
                    mem_req_o   = 1'b1;
                    mem_we_o    = mem_store_i;
                    mem_addr_o  = beat_addr;
                    if (mem_store_i) begin
                        mem_wmask_o = beat_q ? mask2[MW-1:BYTES] : mask2[BYTES-1:0];
                        mem_wdata_o = beat_q ? wdata2[DW-1:XLEN] : wdata2[XLEN-1:0];
                    end
                end
                WAIT: stall_req_o = 1'b1;
                DONE: begin
                    w_enable_o = w_enable_i;
                    w_addr_o   = w_addr_i;
                    w_data_o   = mem_store_i ? w_data_i : ld_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
// Self-checking bench for mem_access_unit (XLEN = 32). The bench acts as the
// data memory (byte-addressed associative array) and predicts load results,
// beats, masks, stall length and memory contents from byte-level rules.
module tb_mem_access_unit;
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 32;
    localparam int unsigned RW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid_i, mem_op_i, mem_store_i, mem_unsigned_i;
    logic [1:0]      mem_size_i;
    logic [AW-1:0]   ram_addr_i;
    logic            w_enable_i;
    logic [RW-1:0]   w_addr_i;
    logic [XLEN-1:0] w_data_i;
    logic            w_enable_o;
    logic [RW-1:0]   w_addr_o;
    logic [XLEN-1:0] w_data_o;
    logic            stall_req_o, fault_o, mem_req_o, mem_we_o;
    logic [AW-1:0]   mem_addr_o;
    logic [3:0]      mem_wmask_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_gnt_i, mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;

    mem_access_unit #(.XLEN(XLEN), .ADDR_W(AW), .REG_ADDR_W(RW)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .mem_op_i(mem_op_i), .mem_store_i(mem_store_i),
        .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i), .ram_addr_i(ram_addr_i),
        .w_enable_i(w_enable_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
        .w_enable_o(w_enable_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
        .stall_req_o(stall_req_o), .fault_o(fault_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wmask_o(mem_wmask_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    logic [109:0] all_outs;
    assign all_outs = {w_enable_o, w_addr_o, w_data_o, stall_req_o, fault_o, mem_req_o,
                       mem_we_o, mem_addr_o, mem_wmask_o, mem_wdata_o};

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [logic [31:0]];

    // Observations collected by run_access.
    int          ob_stall, ob_nbeats;
    bit          ob_done, ob_fault, ob_timeout;
    logic [31:0] ob_addr  [2];
    logic [3:0]  ob_mask  [2];
    logic [31:0] ob_wdat  [2];
    logic        ob_we    [2];
    logic        ob_wen;
    logic [4:0]  ob_waddr;
    logic [31:0] ob_wdata_out;

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] sz, input bit uns,
                                             input logic [31:0] a);
        int n;
        logic [63:0] v;
        n = 1 << sz;
        v = '0;
        for (int i = 0; i < n; i++) v = v | (64'(mem_rd(a + 32'(i))) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v[31:0];
    endfunction

    // Drives one memory instruction and plays the memory side until DONE.
    task automatic run_access(input bit st, input logic [1:0] sz, input bit uns,
                              input logic [31:0] a, input logic [31:0] wd, input bit wen,
                              input logic [4:0] wa, input int gd, input int rd);
        int gcnt, rcnt, cyc;
        bit pend;
        logic [31:0] paddr;
        ob_stall = 0; ob_nbeats = 0; ob_done = 0; ob_fault = 0; ob_timeout = 0;
        gcnt = gd; rcnt = 0; pend = 0; cyc = 0; paddr = '0;
        @(negedge clk);
        in_valid_i = 1; mem_op_i = 1; mem_store_i = st; mem_size_i = sz;
        mem_unsigned_i = uns; ram_addr_i = a; w_enable_i = wen; w_addr_i = wa;
        w_data_i = wd; mem_gnt_i = 0; mem_rvalid_i = 0;
        #1;
        if (stall_req_o) ob_stall++;
        if (fault_o) ob_fault = 1;
        while (!ob_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = $urandom;
            #1;
            if (mem_req_o) begin
                if (gcnt == 0) begin
                    mem_gnt_i = 1;
                    if (ob_nbeats < 2) begin
                        ob_addr[ob_nbeats] = mem_addr_o;
                        ob_mask[ob_nbeats] = mem_wmask_o;
                        ob_wdat[ob_nbeats] = mem_wdata_o;
                        ob_we[ob_nbeats]   = mem_we_o;
                    end
                    ob_nbeats++;
                    if (mem_we_o) begin
                        for (int i = 0; i < 4; i++)
                            if (mem_wmask_o[i]) mem[mem_addr_o + 32'(i)] = mem_wdata_o[8*i +: 8];
                    end else begin
                        pend = 1; paddr = mem_addr_o; rcnt = rd;
                    end
                    // A stray response alongside the grant carries junk data.
                    if ($urandom_range(0, 1) == 1) mem_rvalid_i = 1;
                    gcnt = gd;
                end else begin
                    gcnt--;
                end
            end else if (pend) begin
                if (rcnt == 0) begin
                    mem_rvalid_i = 1;
                    mem_rdata_i = {mem_rd(paddr + 32'd3), mem_rd(paddr + 32'd2),
                                   mem_rd(paddr + 32'd1), mem_rd(paddr)};
                    pend = 0;
                end else begin
                    rcnt--;
                end
            end
            if (stall_req_o) ob_stall++;
            else if (!mem_req_o) begin
                ob_done = 1; ob_wen = w_enable_o; ob_waddr = w_addr_o; ob_wdata_out = w_data_o;
            end
            if (fault_o) ob_fault = 1;
        end
        if (!ob_done) ob_timeout = 1;
        @(negedge clk);
        in_valid_i = 0; mem_op_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 0; in_valid_i = 1; mem_op_i = 1; mem_store_i = 0; mem_size_i = 2;
        ram_addr_i = 32'h100; w_enable_i = 1; w_addr_i = 5'd3; w_data_i = $urandom;
        mem_gnt_i = 1; mem_rvalid_i = 1;
        #1;
        n_tests++;
        if (all_outs !== '0) begin
            n_fail++; $display("FAIL reset_outs_async: got %h expected 0", all_outs);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (all_outs !== '0) begin
            n_fail++; $display("FAIL reset_outs_clocked: got %h expected 0", all_outs);
        end
        @(negedge clk);
        rst = 1; in_valid_i = 0; mem_op_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
        w_enable_i = 1; w_addr_i = 5'd7; w_data_i = 32'hA5A5;
        #1;
        n_tests++;
        if (stall_req_o !== 0 || mem_req_o !== 0 || w_data_o !== 32'hA5A5) begin
            n_fail++;
            $display("FAIL reset_release: got stall=%b req=%b wdata=%h expected 0 0 0000a5a5",
                     stall_req_o, mem_req_o, w_data_o);
        end
    endtask

    task automatic test_passthrough;
        logic [1:0] vm;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vm = 2'($urandom_range(0, 2));
            in_valid_i = vm[0]; mem_op_i = vm[1];
            mem_store_i = 1'($urandom); mem_size_i = 2'($urandom);
            ram_addr_i = $urandom; w_enable_i = 1'($urandom); w_addr_i = 5'($urandom);
            w_data_i = (i == 0) ? 32'h55 : $urandom;
            mem_rvalid_i = 1'($urandom); mem_rdata_i = $urandom;
            #1;
            n_tests++;
            if ({w_enable_o, w_addr_o, w_data_o} !== {w_enable_i, w_addr_i, w_data_i}) begin
                n_fail++;
                $display("FAIL passthru_w: got %b %h %h expected %b %h %h", w_enable_o, w_addr_o,
                         w_data_o, w_enable_i, w_addr_i, w_data_i);
            end
            n_tests++;
            if ({stall_req_o, mem_req_o, fault_o} !== 3'b000) begin
                n_fail++;
                $display("FAIL passthru_ctl: got stall/req/fault=%b%b%b expected 000",
                         stall_req_o, mem_req_o, fault_o);
            end
        end
        @(negedge clk);
        in_valid_i = 0; mem_op_i = 0; mem_rvalid_i = 0;
    endtask

    task automatic test_load_basic;
        mem[32'h100] = 8'hEF; mem[32'h101] = 8'hBE; mem[32'h102] = 8'hAD; mem[32'h103] = 8'hDE;
        run_access(0, 2'd2, 0, 32'h100, 32'h0, 1, 5'd4, 1, 0);
        n_tests++;
        if (!ob_done || ob_wdata_out !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL lw_data: got %h expected deadbeef", ob_wdata_out);
        end
        n_tests++;
        if (ob_stall != 4) begin
            n_fail++; $display("FAIL lw_stall_cycles: got %0d expected 4", ob_stall);
        end
        mem[32'h100] = 8'h00; mem[32'h101] = 8'h00; mem[32'h102] = 8'h00; mem[32'h103] = 8'h80;
        run_access(0, 2'd0, 0, 32'h103, 32'h0, 1, 5'd5, 0, 0);
        n_tests++;
        if (!ob_done || ob_wdata_out !== 32'hFFFFFF80) begin
            n_fail++; $display("FAIL lb_sign: got %h expected ffffff80", ob_wdata_out);
        end
        run_access(0, 2'd0, 1, 32'h103, 32'h0, 1, 5'd5, 0, 1);
        n_tests++;
        if (!ob_done || ob_wdata_out !== 32'h00000080) begin
            n_fail++; $display("FAIL lbu_zero: got %h expected 00000080", ob_wdata_out);
        end
    endtask

    task automatic test_store_basic;
        run_access(1, 2'd1, 0, 32'h102, 32'h1234, 1, 5'd6, 0, 0);
        n_tests++;
        if (ob_nbeats != 1 || ob_mask[0] !== 4'b1100 || ob_wdat[0][31:16] !== 16'h1234 ||
            ob_we[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sh_beat: got beats=%0d mask=%b wdata=%h we=%b expected 1 1100 1234xxxx 1",
                     ob_nbeats, ob_mask[0], ob_wdat[0], ob_we[0]);
        end
        n_tests++;
        if (!ob_done || ob_wdata_out !== 32'h1234) begin
            n_fail++; $display("FAIL sh_writeback: got %h expected 00001234", ob_wdata_out);
        end
    endtask

    task automatic test_fault;
        int kind, kmax;
`ifdef MEM_MISALIGN_SPLIT_EN
        kmax = 0;
`else
        kmax = 2;
`endif
        for (int i = 0; i < 12; i++) begin
            kind = $urandom_range(0, kmax);
            @(negedge clk);
            in_valid_i = 1; mem_op_i = 1; mem_store_i = 1'($urandom);
            mem_unsigned_i = 1'($urandom); w_enable_i = 1; w_data_i = $urandom;
            case (kind)
                0:       begin mem_size_i = 2'd3; ram_addr_i = $urandom; end
                1:       begin mem_size_i = 2'd1; ram_addr_i = $urandom | 32'd1; end
                default: begin
                    mem_size_i = 2'd2;
                    ram_addr_i = ($urandom & ~32'd3) | 32'($urandom_range(1, 3));
                end
            endcase
            #1;
            n_tests++;
            if ({fault_o, stall_req_o, w_enable_o, mem_req_o} !== 4'b1000) begin
                n_fail++;
                $display("FAIL fault_pulse: got fault/stall/wen/req=%b%b%b%b expected 1000 (size %0d addr %h)",
                         fault_o, stall_req_o, w_enable_o, mem_req_o, mem_size_i, ram_addr_i);
            end
            @(negedge clk);
            in_valid_i = 0; mem_op_i = 0;
            #1;
            n_tests++;
            if ({fault_o, stall_req_o, mem_req_o} !== 3'b000) begin
                n_fail++;
                $display("FAIL fault_after: got fault/stall/req=%b%b%b expected 000",
                         fault_o, stall_req_o, mem_req_o);
            end
        end
    endtask

    task automatic test_split;
`ifdef MEM_MISALIGN_SPLIT_EN
        run_access(1, 2'd2, 0, 32'hFFFFFFFE, 32'hCAFEF00D, 1, 5'd8, 1, 0);
        n_tests++;
        if (ob_nbeats != 2 || ob_addr[0] !== 32'hFFFFFFFC || ob_mask[0] !== 4'b1100 ||
            ob_addr[1] !== 32'h0 || ob_mask[1] !== 4'b0011) begin
            n_fail++;
            $display("FAIL split_sw_wrap: got %0d beats %h/%b %h/%b expected 2 fffffffc/1100 00000000/0011",
                     ob_nbeats, ob_addr[0], ob_mask[0], ob_addr[1], ob_mask[1]);
        end
`else
        int reqs;
        reqs = 0;
        @(negedge clk);
        in_valid_i = 1; mem_op_i = 1; mem_store_i = 1; mem_size_i = 2'd2;
        ram_addr_i = 32'hFFFFFFFE; w_enable_i = 1; w_data_i = 32'hCAFEF00D;
        #1;
        n_tests++;
        if (fault_o !== 1'b1) begin
            n_fail++; $display("FAIL nosplit_sw_fault: got fault=%b expected 1", fault_o);
        end
        for (int i = 0; i < 3; i++) begin
            if (mem_req_o === 1'b1) reqs++;
            @(negedge clk);
            in_valid_i = 0; mem_op_i = 0;
            #1;
        end
        n_tests++;
        if (reqs != 0 || mem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL nosplit_sw_noreq: got %0d request cycles expected 0", reqs);
        end
`endif
    endtask

    task automatic test_random_access(input int iters);
        bit st, uns, wen;
        logic [1:0] sz;
        logic [31:0] a, wd, base, b, exp_ld, bm;
        logic [4:0] wa;
        logic [7:0] old [8];
        logic [63:0] exp_v, act_v;
        logic [3:0] exp_mask;
        int n, nbe, gd, rd, exp_stall, kk;
        for (int it = 0; it < iters; it++) begin
            st = 1'($urandom); uns = 1'($urandom); wen = 1'($urandom);
            sz = 2'($urandom_range(0, 2)); n = 1 << sz;
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15))
                                            : 32'h100 + 32'($urandom_range(0, 63));
`ifndef MEM_MISALIGN_SPLIT_EN
            a = a & ~(32'(n) - 32'd1);
`endif
            wd = $urandom; wa = 5'($urandom);
            gd = $urandom_range(0, 3); rd = $urandom_range(0, 3);
            base = a & ~32'd3;
            nbe = (base != ((a + 32'(n) - 32'd1) & ~32'd3)) ? 2 : 1;
            exp_stall = 1 + nbe * (gd + 1) + (st ? 0 : nbe * (rd + 1));
            exp_ld = exp_load(sz, uns, a);
            for (int k = 0; k < 8; k++) old[k] = mem_rd(base + 32'(k));

            run_access(st, sz, uns, a, wd, wen, wa, gd, rd);

            n_tests++;
            if (ob_timeout || ob_fault) begin
                n_fail++;
                $display("FAIL rnd_complete: got timeout=%b fault=%b expected 0 0 (addr %h size %0d)",
                         ob_timeout, ob_fault, a, sz);
            end
            n_tests++;
            if (ob_stall != exp_stall) begin
                n_fail++;
                $display("FAIL rnd_stall: got %0d expected %0d (addr %h size %0d st %b)",
                         ob_stall, exp_stall, a, sz, st);
            end
            n_tests++;
            if (ob_nbeats != nbe) begin
                n_fail++; $display("FAIL rnd_beats: got %0d expected %0d (addr %h)", ob_nbeats, nbe, a);
            end
            for (int k = 0; k < 2; k++) begin
                if (k < nbe && k < ob_nbeats) begin
                    bm = base + 32'(4 * k);
                    for (int i = 0; i < 4; i++) exp_mask[i] = ((bm + 32'(i) - a) < 32'(n));
                    n_tests++;
                    if (ob_addr[k] !== bm || ob_we[k] !== st || (st && ob_mask[k] !== exp_mask)) begin
                        n_fail++;
                        $display("FAIL rnd_beat%0d: got addr=%h we=%b mask=%b expected %h %b %b",
                                 k, ob_addr[k], ob_we[k], ob_mask[k], bm, st, exp_mask);
                    end
                end
            end
            n_tests++;
            if (ob_wen !== wen || ob_waddr !== wa || ob_wdata_out !== (st ? wd : exp_ld)) begin
                n_fail++;
                $display("FAIL rnd_writeback: got %b %h %h expected %b %h %h (addr %h size %0d uns %b)",
                         ob_wen, ob_waddr, ob_wdata_out, wen, wa, st ? wd : exp_ld, a, sz, uns);
            end
            if (st) begin
                for (int k = 0; k < 8; k++) begin
                    b = base + 32'(k);
                    kk = int'(b - a);
                    exp_v[8*k +: 8] = ((b - a) < 32'(n)) ? wd[8*kk +: 8] : old[k];
                    act_v[8*k +: 8] = mem_rd(b);
                end
                n_tests++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL rnd_store_mem: got %h expected %h (addr %h size %0d)",
                             act_v, exp_v, a, sz);
                end
            end
        end
    endtask

    task automatic test_reset_in_wait;
        @(negedge clk);
        in_valid_i = 1; mem_op_i = 1; mem_store_i = 0; mem_size_i = 2'd2;
        mem_unsigned_i = 0; ram_addr_i = 32'h100; w_enable_i = 1; w_addr_i = 5'd2;
        mem_gnt_i = 0; mem_rvalid_i = 0;
        @(negedge clk);
        mem_gnt_i = 1;
        #1;
        n_tests++;
        if (mem_req_o !== 1'b1) begin
            n_fail++; $display("FAIL rstwait_req: got req=%b expected 1", mem_req_o);
        end
        @(negedge clk);
        mem_gnt_i = 0;
        #1;
        n_tests++;
        if (mem_req_o !== 1'b0 || stall_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rstwait_wait: got req=%b stall=%b expected 0 1", mem_req_o, stall_req_o);
        end
        rst = 0;
        #1;
        n_tests++;
        if (all_outs !== '0) begin
            n_fail++; $display("FAIL rstwait_outs: got %h expected 0", all_outs);
        end
        @(negedge clk);
        rst = 1; in_valid_i = 0; mem_op_i = 0; w_enable_i = 0;
        mem_rvalid_i = 1; mem_rdata_i = $urandom;
        #1;
        n_tests++;
        if ({mem_req_o, stall_req_o, w_enable_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstwait_idle: got req/stall/wen=%b%b%b expected 000",
                     mem_req_o, stall_req_o, w_enable_o);
        end
        @(negedge clk);
        mem_rvalid_i = 0; w_enable_i = 1; w_addr_i = 5'd9; w_data_i = 32'h55;
        #1;
        n_tests++;
        if (w_data_o !== 32'h55 || w_enable_o !== 1'b1 || stall_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstwait_pass: got wdata=%h wen=%b stall=%b expected 00000055 1 0",
                     w_data_o, w_enable_o, stall_req_o);
        end
        mem[32'h108] = 8'h11; mem[32'h109] = 8'h22; mem[32'h10A] = 8'h33; mem[32'h10B] = 8'h44;
        run_access(0, 2'd2, 0, 32'h108, 32'h0, 1, 5'd10, 0, 2);
        n_tests++;
        if (!ob_done || ob_wdata_out !== 32'h44332211) begin
            n_fail++; $display("FAIL rstwait_recover: got %h expected 44332211", ob_wdata_out);
        end
    endtask

    initial begin
        rst = 0; in_valid_i = 0; mem_op_i = 0; mem_store_i = 0; mem_size_i = 0;
        mem_unsigned_i = 0; ram_addr_i = 0; w_enable_i = 0; w_addr_i = 0; w_data_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        test_reset();
        test_passthrough();
        test_load_basic();
        test_store_basic();
        test_fault();
        test_split();
        test_random_access(40);
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
